// File: rtl/ifetch_ctrl.sv
// ifetch_ctrl: instruction-fetch sequencer.
// Owns the PC, drives the instruction-memory byte address and captures each
// fetched word into the IF/ID slot under a valid/ready handshake. Handles
// decode back-pressure, EX-stage redirects, start/halt control and
// misaligned redirect targets (which park the block in ERR until reset).
module ifetch_ctrl #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          MEM_BYTES = 1024,
  parameter int          CNT_W     = 16,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             halt_req,
  input  logic             id_ready,
  input  logic             redirect_valid,
  input  logic [31:0]      redirect_pc,
  output logic [31:0]      imem_addr,
  input  logic [31:0]      imem_rdata,
  output logic             if_valid,
  output logic [31:0]      if_pc,
  output logic [31:0]      if_instr,
  output logic [CNT_W-1:0] fetch_cnt,
  output logic             misalign_err,
  output logic [1:0]       state
);

  // PC arithmetic wraps modulo the memory size, which must be a power of two.
  localparam logic [31:0] PC_MASK = 32'(MEM_BYTES - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_HALT = 2'd2,
    S_ERR  = 2'd3
  } state_e;

  state_e             state_q;
  logic [31:0]        pc_q;
  logic               if_valid_q;
  logic [31:0]        if_pc_q;
  logic [31:0]        if_instr_q;
  logic [CNT_W-1:0]   fetch_cnt_q;
  logic               misalign_err_q;

  // Combinational helpers feeding the state register.
  logic               slot_free_d;
  logic               redir_misaligned_d;
  logic [31:0]        pc_seq_d;
  logic [31:0]        pc_redir_d;

  assign slot_free_d        = !if_valid_q || id_ready;
  assign redir_misaligned_d = (redirect_pc[1:0] != 2'b00);
  assign pc_seq_d           = (pc_q + 32'd4) & PC_MASK;
  assign pc_redir_d         = redirect_pc & PC_MASK;

  // Fetch FSM together with the PC, IF/ID slot, counter and sticky error flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= S_IDLE;
      pc_q           <= RESET_PC;
      if_valid_q     <= 1'b0;
      if_pc_q        <= 32'h0000_0000;
      if_instr_q     <= NOP_INSTR;
      fetch_cnt_q    <= '0;
      misalign_err_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          // Redirects and halt requests are meaningless before fetching starts.
          if (start) begin
            state_q <= S_RUN;
          end
        end

        S_RUN: begin
          if (redirect_valid) begin
            // A taken control transfer always flushes the slot, stalled or not.
            if_valid_q <= 1'b0;
            if (redir_misaligned_d) begin
              state_q        <= S_ERR;
              misalign_err_q <= 1'b1;
            end else begin
              pc_q <= pc_redir_d;
              if (halt_req) begin
                state_q <= S_HALT;
              end
            end
          end else if (halt_req) begin
            // Keep the current slot; decode drains it while halted.
            state_q <= S_HALT;
          end else if (slot_free_d) begin
            if_instr_q <= imem_rdata;
            if_pc_q    <= pc_q;
            if_valid_q <= 1'b1;
            pc_q       <= pc_seq_d;
            if (fetch_cnt_q != {CNT_W{1'b1}}) begin
              fetch_cnt_q <= fetch_cnt_q + 1'b1;
            end
          end
        end

        S_HALT: begin
          if (id_ready) begin
            if_valid_q <= 1'b0;
          end
          if (redirect_valid && redir_misaligned_d) begin
            state_q        <= S_ERR;
            misalign_err_q <= 1'b1;
            if_valid_q     <= 1'b0;
          end else begin
            if (redirect_valid) begin
              pc_q <= pc_redir_d;
            end
            if (start) begin
              state_q <= S_RUN;
            end
          end
        end

        S_ERR: begin
          // Terminal until reset.
          if_valid_q <= 1'b0;
        end

        default: begin
          state_q <= S_ERR;
        end
      endcase
    end
  end

  assign imem_addr    = pc_q;
  assign if_valid     = if_valid_q;
  assign if_pc        = if_pc_q;
  assign if_instr     = if_instr_q;
  assign fetch_cnt    = fetch_cnt_q;
  assign misalign_err = misalign_err_q;
  assign state        = state_q;

endmodule

// File: tb/tb_ifetch_ctrl.sv
// Testbench for ifetch_ctrl: directed scenarios with literal expectations
// plus a randomized run, all checked every cycle against a behavioural model.
module tb_ifetch_ctrl;

  localparam int          MEM   = 1024;
  localparam int          CW    = 4;
  localparam int          CMAX  = (1 << CW) - 1;
  localparam logic [31:0] NOP   = 32'h0000_0013;

  logic          clk;
  logic          rst_n;
  logic          start;
  logic          halt_req;
  logic          id_ready;
  logic          redirect_valid;
  logic [31:0]   redirect_pc;
  logic [31:0]   imem_addr;
  logic [31:0]   imem_rdata;
  logic          if_valid;
  logic [31:0]   if_pc;
  logic [31:0]   if_instr;
  logic [CW-1:0] fetch_cnt;
  logic          misalign_err;
  logic [1:0]    state;

  logic [31:0] mem [MEM/4];

  int n_vec;
  int n_err;
  bit cmp_en;

  ifetch_ctrl #(
    .RESET_PC (32'h0000_0000),
    .MEM_BYTES(MEM),
    .CNT_W    (CW),
    .NOP_INSTR(NOP)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .start         (start),
    .halt_req      (halt_req),
    .id_ready      (id_ready),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .imem_addr     (imem_addr),
    .imem_rdata    (imem_rdata),
    .if_valid      (if_valid),
    .if_pc         (if_pc),
    .if_instr      (if_instr),
    .fetch_cnt     (fetch_cnt),
    .misalign_err  (misalign_err),
    .state         (state)
  );

  // Combinational instruction memory.
  assign imem_rdata = mem[imem_addr[9:2]];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // State as a plain number: 0 idle, 1 running, 2 halted, 3 error.
  int          m_state;
  logic [31:0] m_pc;
  logic        m_v;
  logic [31:0] m_ipc;
  logic [31:0] m_ins;
  int          m_cnt;
  logic        m_err;

  always @(posedge clk or negedge rst_n) begin : model
    int          st;
    logic [31:0] pc;
    logic        v;
    logic [31:0] ipc;
    logic [31:0] ins;
    int          cnt;
    logic        e;
    bit          bad;
    if (!rst_n) begin
      m_state <= 0;
      m_pc    <= 32'h0;
      m_v     <= 1'b0;
      m_ipc   <= 32'h0;
      m_ins   <= NOP;
      m_cnt   <= 0;
      m_err   <= 1'b0;
    end else begin
      st = m_state; pc = m_pc; v = m_v; ipc = m_ipc; ins = m_ins; cnt = m_cnt; e = m_err;
      bad = (redirect_pc % 4) != 0;
      if (st == 0) begin
        if (start) st = 1;
      end else if (st == 1) begin
        if (redirect_valid) begin
          v = 1'b0;
          if (bad) begin
            st = 3; e = 1'b1;
          end else begin
            pc = redirect_pc % MEM;
            if (halt_req) st = 2;
          end
        end else if (halt_req) begin
          st = 2;
        end else if (!m_v || id_ready) begin
          ins = mem[m_pc / 4];
          ipc = m_pc;
          v   = 1'b1;
          pc  = (m_pc + 4) % MEM;
          if (cnt < CMAX) cnt = cnt + 1;
        end
      end else if (st == 2) begin
        if (id_ready) v = 1'b0;
        if (redirect_valid && bad) begin
          st = 3; e = 1'b1; v = 1'b0;
        end else begin
          if (redirect_valid) pc = redirect_pc % MEM;
          if (start) st = 1;
        end
      end else begin
        v = 1'b0;
      end
      m_state <= st; m_pc <= pc; m_v <= v; m_ipc <= ipc; m_ins <= ins; m_cnt <= cnt; m_err <= e;
    end
  end

  // Per-cycle comparison against the model, on the falling edge.
  always @(negedge clk) begin
    if (cmp_en) begin
      chk("m.state",     {30'b0, state},        32'(m_state));
      chk("m.imem_addr", imem_addr,             m_pc);
      chk("m.if_valid",  {31'b0, if_valid},     {31'b0, m_v});
      chk("m.if_pc",     if_pc,                 m_ipc);
      chk("m.if_instr",  if_instr,              m_ins);
      chk("m.fetch_cnt", {28'b0, fetch_cnt},    32'(m_cnt));
      chk("m.misalign",  {31'b0, misalign_err}, {31'b0, m_err});
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, ".state"},     {30'b0, state},        32'd0);
    chk({tag, ".imem_addr"}, imem_addr,             32'h0);
    chk({tag, ".if_valid"},  {31'b0, if_valid},     32'd0);
    chk({tag, ".if_pc"},     if_pc,                 32'h0);
    chk({tag, ".if_instr"},  if_instr,              NOP);
    chk({tag, ".fetch_cnt"}, {28'b0, fetch_cnt},    32'd0);
    chk({tag, ".misalign"},  {31'b0, misalign_err}, 32'd0);
  endtask

  initial begin
    n_vec = 0; n_err = 0; cmp_en = 1'b0;
    rst_n = 1'b0; start = 1'b0; halt_req = 1'b0; id_ready = 1'b0;
    redirect_valid = 1'b0; redirect_pc = 32'h0;
    for (int i = 0; i < MEM/4; i++) mem[i] = $urandom;

    step();
    cmp_en = 1'b1;
    step();
    chk_reset_vals("T1.reset");
    rst_n = 1'b1;

    // T1: start, then sequential captures.
    start = 1'b1; id_ready = 1'b1;
    step();
    chk("T1.state_run", {30'b0, state}, 32'd1);
    start = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      chk("T1.if_pc",    if_pc,    32'(k * 4));
      chk("T1.if_instr", if_instr, mem[k]);
    end

    // T2: stall three cycles with if_pc=8 in the slot.
    id_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      chk("T2.if_pc_hold", if_pc,              32'h8);
      chk("T2.pc_hold",    imem_addr,          32'hC);
      chk("T2.cnt_hold",   {28'b0, fetch_cnt}, 32'd3);
    end
    id_ready = 1'b1;
    step();
    chk("T2.if_pc_next", if_pc,              32'hC);
    chk("T2.if_instr",   if_instr,           mem[3]);
    chk("T1.fetch_cnt",  {28'b0, fetch_cnt}, 32'd4);

    // T3: redirect while stalled flushes, then fetches from the target.
    id_ready = 1'b0;
    step();
    redirect_valid = 1'b1; redirect_pc = 32'h40;
    step();
    chk("T3.flush", {31'b0, if_valid}, 32'd0);
    redirect_valid = 1'b0; id_ready = 1'b1;
    step();
    chk("T3.if_pc",    if_pc,    32'h40);
    chk("T3.if_instr", if_instr, mem[16]);

    // T5: wrap at the top of memory, halt, drain, resume.
    redirect_valid = 1'b1; redirect_pc = 32'h3FC;
    step();
    redirect_valid = 1'b0;
    step();
    chk("T5.if_pc_top", if_pc, 32'h3FC);
    step();
    chk("T5.if_pc_wrap", if_pc, 32'h0);
    halt_req = 1'b1; id_ready = 1'b0;
    step();
    chk("T5.state_halt", {30'b0, state},    32'd2);
    chk("T5.slot_kept",  {31'b0, if_valid}, 32'd1);
    halt_req = 1'b0; id_ready = 1'b1;
    step();
    chk("T5.drained", {31'b0, if_valid}, 32'd0);
    chk("T5.pc_keep", if_pc,             32'h0);
    start = 1'b1;
    step();
    chk("T5.state_run", {30'b0, state}, 32'd1);
    start = 1'b0;
    step();
    chk("T5.resume_pc", if_pc,              32'h4);
    chk("T5.fetch_cnt", {28'b0, fetch_cnt}, 32'd8);

    // T6: asynchronous reset mid-stream.
    chk("T6.pre_valid", {31'b0, if_valid}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk_reset_vals("T6");
    step();
    rst_n = 1'b1;

    // T4: misaligned redirect is terminal until reset.
    start = 1'b1;
    step();
    start = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'h42;
    step();
    chk("T4.state_err", {30'b0, state},        32'd3);
    chk("T4.misalign",  {31'b0, misalign_err}, 32'd1);
    chk("T4.if_valid",  {31'b0, if_valid},     32'd0);
    redirect_valid = 1'b0; start = 1'b1;
    step();
    chk("T4.start_ignored", {30'b0, state}, 32'd3);
    start = 1'b0;
    rst_n = 1'b0;
    #1;
    chk_reset_vals("T4.reset");
    step();
    rst_n = 1'b1;

    // Randomized run against the model, with occasional resets.
    for (int c = 0; c < 3000; c++) begin
      int r;
      start    = ($urandom % 8) == 0;
      halt_req = ($urandom % 20) == 0;
      id_ready = ($urandom % 10) < 7;
      redirect_valid = ($urandom % 16) == 0;
      r = $urandom;
      redirect_pc = (($urandom % 12) == 0) ? (r | 32'h1) : (r & ~32'h3);
      if (($urandom % 250) == 0) rst_n = 1'b0;
      step();
      rst_n = 1'b1;
    end

    start = 1'b0; halt_req = 1'b0; redirect_valid = 1'b0;
    step();
    cmp_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
